decode_queue: RTL and testbench

Registered, parametrised instruction-decode stage with valid/ready handshakes on both sides and a DEPTH-entry queue of decoded records between fetch and execute. Each accepted 32-bit instruction (plus its PC) is decoded into opcode, register indices, funct fields, XLEN-wide immediate, ALU control and an illegal-instruction flag, then buffered until execute consumes it. ALU control comes from an `ALUdecoder` instance. A synchronous flush discards all buffered records on a branch or jump redirect.

---
 rtl/decode_queue.sv | 239 +++++++++++++++++++++++
 tb/tb_decode_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Instruction decode stage: combinational RV32I-style decode feeding a small
// circular queue of decoded records, with valid/ready on both sides and flush.

module ALUdecoder (
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_control_o
);
    // alu_op: 00 add, 01 branch compare, 10 register op, 11 no ALU use
    always_comb begin
        alu_control_o = 4'b1111;
        case (alu_op_i)
            2'b00: alu_control_o = 4'b0000;
            2'b01: begin
                case (funct3_i[2:1])
                    2'b10:   alu_control_o = 4'b0011;
                    2'b11:   alu_control_o = 4'b0100;
                    default: alu_control_o = 4'b0001;
                endcase
            end
            2'b10: begin
                case (funct3_i)
                    3'b000:  alu_control_o = funct7b5_i ? 4'b0001 : 4'b0000;
                    3'b001:  alu_control_o = 4'b0010;
                    3'b010:  alu_control_o = 4'b0011;
                    3'b011:  alu_control_o = 4'b0100;
                    3'b100:  alu_control_o = 4'b0101;
                    3'b101:  alu_control_o = funct7b5_i ? 4'b0111 : 4'b0110;
                    3'b110:  alu_control_o = 4'b1000;
                    default: alu_control_o = 4'b1001;
                endcase
            end
            default: alu_control_o = 4'b1111;
        endcase
    end
endmodule

module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [31:0]                out_instr,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [2:0]                 out_funct3,
    output logic [6:0]                 out_funct7,
    output logic [XLEN-1:0]            out_imm,
    output logic [3:0]                 out_alu_control,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_ILOG  = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu_control;
        logic            illegal;
    } rec_t;

    logic [6:0]  opc;
    logic [31:0] imm32;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic        illegal;
    rec_t        dec_rec;

    assign opc = in_instr[6:0];

    ALUdecoder u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (in_instr[14:12]),
        .funct7b5_i    (in_instr[30]),
        .alu_control_o (alu_ctrl)
    );

    always_comb begin
        dec_rec        = '0;
        imm32          = '0;
        alu_op         = 2'b11;
        illegal        = 1'b0;
        dec_rec.instr  = in_instr;
        dec_rec.pc     = in_pc;
        dec_rec.opcode = opc;
        case (opc)
            OP_R: begin
                dec_rec.rd     = in_instr[11:7];
                dec_rec.rs1    = in_instr[19:15];
                dec_rec.rs2    = in_instr[24:20];
                dec_rec.funct3 = in_instr[14:12];
                dec_rec.funct7 = in_instr[31:25];
                alu_op         = 2'b10;
                illegal        = (in_instr[31:25] != 7'b0000000) && (in_instr[31:25] != 7'b0100000);
            end
            OP_ILOG, OP_LOAD, OP_JALR: begin
                dec_rec.rd  = in_instr[11:7];
                dec_rec.rs1 = in_instr[19:15];
                imm32       = {{20{in_instr[31]}}, in_instr[31:20]};
                if (opc != OP_JALR) dec_rec.funct3 = in_instr[14:12];
                if (opc == OP_ILOG) dec_rec.funct7 = in_instr[31:25];
                if (opc != OP_ILOG) alu_op = 2'b00;
                illegal = (opc == OP_JALR) && (in_instr[14:12] != 3'b000);
            end
            OP_S: begin
                dec_rec.rs1    = in_instr[19:15];
                dec_rec.rs2    = in_instr[24:20];
                dec_rec.funct3 = in_instr[14:12];
                imm32          = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                alu_op         = 2'b00;
            end
            OP_B: begin
                dec_rec.rs1    = in_instr[19:15];
                dec_rec.rs2    = in_instr[24:20];
                dec_rec.funct3 = in_instr[14:12];
                imm32          = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                  in_instr[30:25], in_instr[11:8], 1'b0};
                alu_op         = 2'b01;
                illegal        = (in_instr[14:13] == 2'b01);
            end
            OP_J: begin
                dec_rec.rd = in_instr[11:7];
                imm32      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                              in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_AUIPC, OP_LUI: begin
                dec_rec.rd = in_instr[11:7];
                imm32      = {in_instr[31:12], 12'b0};
                alu_op     = 2'b00;
            end
            OP_FENCE: ;
            default: illegal = 1'b1;
        endcase
        if (in_instr[1:0] != 2'b11) illegal = 1'b1;
        dec_rec.imm         = XLEN'($signed(imm32));
        dec_rec.alu_control = alu_ctrl;
        // Illegal records keep only pc and raw instruction so execute can trap.
        if (illegal) begin
            dec_rec             = '0;
            dec_rec.instr       = in_instr;
            dec_rec.pc          = in_pc;
            dec_rec.illegal     = 1'b1;
        end
    end

    rec_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    rec_t             head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) return '0;
        return PTR_W'(p + 1'b1);
    endfunction

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_rec;
    end

    // Empty queue (including straight after reset) presents an all-zero record.
    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign count           = count_q;
    assign out_pc          = head.pc;
    assign out_instr       = head.instr;
    assign out_opcode      = head.opcode;
    assign out_rd          = head.rd;
    assign out_rs1         = head.rs1;
    assign out_rs2         = head.rs2;
    assign out_funct3      = head.funct3;
    assign out_funct7      = head.funct7;
    assign out_imm         = head.imm;
    assign out_alu_control = head.alu_control;
    assign out_illegal     = head.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: a reference decoder predicts each record
// at push time; the head of the expected queue is compared every cycle.

module tb_decode_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = '0;
    logic [XLEN-1:0]   in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_instr;
    logic [6:0]        out_opcode;
    logic [4:0]        out_rd, out_rs1, out_rs2;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [XLEN-1:0]   out_imm;
    logic [3:0]        out_alu_control;
    logic              out_illegal;
    logic [CNT_W-1:0]  count;

    decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_alu_control(out_alu_control), .out_illegal(out_illegal), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [6:0]      op;
        logic [4:0]      rd, rs1, rs2;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [XLEN-1:0] imm;
        logic [3:0]      alu;
        logic            ill;
    } rec_t;

    rec_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   n_acc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rec_t model(input logic [31:0] i, input logic [XLEN-1:0] pc);
        rec_t r;
        logic signed [31:0] s;
        logic [31:0] imm;
        logic [6:0] op;
        logic known, bad;
        s = $signed(i);
        op = i[6:0];
        imm = 32'h0;
        r.instr = i; r.pc = pc; r.op = op;
        r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.f3 = 0; r.f7 = 0; r.alu = 4'hF; r.ill = 0;
        known = 1'b1; bad = 1'b0;
        case (op)
            7'h33: begin
                r.rd = i[11:7]; r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.f3 = i[14:12]; r.f7 = i[31:25];
                bad = !(i[31:25] == 7'h00 || i[31:25] == 7'h20);
                case (i[14:12])
                    3'd0: r.alu = i[30] ? 4'd1 : 4'd0;
                    3'd1: r.alu = 4'd2;
                    3'd2: r.alu = 4'd3;
                    3'd3: r.alu = 4'd4;
                    3'd4: r.alu = 4'd5;
                    3'd5: r.alu = i[30] ? 4'd7 : 4'd6;
                    3'd6: r.alu = 4'd8;
                    default: r.alu = 4'd9;
                endcase
            end
            7'h13: begin
                r.rd = i[11:7]; r.rs1 = i[19:15]; r.f3 = i[14:12]; r.f7 = i[31:25];
                imm = 32'(s >>> 20);
            end
            7'h03: begin
                r.rd = i[11:7]; r.rs1 = i[19:15]; r.f3 = i[14:12];
                imm = 32'(s >>> 20); r.alu = 4'd0;
            end
            7'h67: begin
                r.rd = i[11:7]; r.rs1 = i[19:15];
                imm = 32'(s >>> 20); r.alu = 4'd0; bad = (i[14:12] != 3'd0);
            end
            7'h23: begin
                r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.f3 = i[14:12];
                imm = (32'(s >>> 20) & 32'hFFFF_FFE0) | 32'(i[11:7]); r.alu = 4'd0;
            end
            7'h63: begin
                r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.f3 = i[14:12];
                imm = (32'(s >>> 19) & 32'hFFFF_F000) | (32'(i[7]) << 11)
                    | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
                bad = (i[14:12] == 3'd2) || (i[14:12] == 3'd3);
                if (i[14:12] >= 3'd6)      r.alu = 4'd4;
                else if (i[14:12] >= 3'd4) r.alu = 4'd3;
                else                       r.alu = 4'd1;
            end
            7'h6F: begin
                r.rd = i[11:7];
                imm = (32'(s >>> 11) & 32'hFFF0_0000) | (32'(i[19:12]) << 12)
                    | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
            end
            7'h17, 7'h37: begin
                r.rd = i[11:7]; imm = i & 32'hFFFF_F000; r.alu = 4'd0;
            end
            7'h0F: ;
            default: known = 1'b0;
        endcase
        r.imm = XLEN'($signed(imm));
        if (!known || bad || i[1:0] != 2'b11) begin
            r.op = 0; r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.f3 = 0; r.f7 = 0;
            r.imm = 0; r.alu = 0; r.ill = 1'b1;
        end
        return r;
    endfunction

    task automatic check_outputs();
        int sz;
        rec_t e;
        sz = exp_q.size();
        check("count", 64'(count), 64'(sz));
        check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
        check("out_valid", 64'(out_valid), 64'(sz != 0));
        if (sz != 0) begin
            e = exp_q[0];
            check("out_pc", 64'(out_pc), 64'(e.pc));
            check("out_instr", 64'(out_instr), 64'(e.instr));
            check("out_opcode", 64'(out_opcode), 64'(e.op));
            check("out_rd", 64'(out_rd), 64'(e.rd));
            check("out_rs1", 64'(out_rs1), 64'(e.rs1));
            check("out_rs2", 64'(out_rs2), 64'(e.rs2));
            check("out_funct3", 64'(out_funct3), 64'(e.f3));
            check("out_funct7", 64'(out_funct7), 64'(e.f7));
            check("out_imm", 64'(out_imm), 64'(e.imm));
            check("out_alu", 64'(out_alu_control), 64'(e.alu));
            check("out_illegal", 64'(out_illegal), 64'(e.ill));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_pc"}, 64'(out_pc), 64'd0);
        check({tag, "_instr"}, 64'(out_instr), 64'd0);
        check({tag, "_imm"}, 64'(out_imm), 64'd0);
        check({tag, "_rd"}, 64'(out_rd), 64'd0);
        check({tag, "_alu"}, 64'(out_alu_control), 64'd0);
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                         input logic ordy, input logic fl);
        logic acc, ret;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        @(posedge clk);
        acc = v && (exp_q.size() < DEPTH) && !fl;
        ret = (exp_q.size() != 0) && ordy && !fl;
        if (fl) begin
            $display("flush dropped=%0d", exp_q.size());
            exp_q.delete();
        end else begin
            if (ret) begin
                $display("retire pc=%0h instr=%08h", exp_q[0].pc, exp_q[0].instr);
                void'(exp_q.pop_front());
            end
            if (acc) begin
                $display("accept pc=%0h instr=%08h", pc, ins);
                exp_q.push_back(model(ins, pc));
                n_acc++;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * DEPTH + 2 && exp_q.size() != 0; k++) cycle(0, 0, 0, 1, 0);
        check("drained", 64'(count), 64'd0);
    endtask

    logic [31:0] prog [14] = '{
        32'hFFF00093, 32'h002081B3, 32'h402081B3, 32'h0020A423, 32'hFE000EE3,
        32'h123452B7, 32'h00001097, 32'h008000EF, 32'h0040A103, 32'h0020C463,
        32'h4010D093, 32'h0FF0000F, 32'h00008067, 32'h0020F1B3
    };

    initial begin
        // Reset
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("rst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Single instruction, held
        cycle(1, 32'hFFF00093, 32'h100, 0, 0);
        check("addi_rd", 64'(out_rd), 64'd1);
        check("addi_rs1", 64'(out_rs1), 64'd0);
        check("addi_f3", 64'(out_funct3), 64'd0);
        check("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
        check("addi_pc", 64'(out_pc), 64'h100);
        check("addi_count", 64'(count), 64'd1);
        cycle(0, 0, 0, 0, 0);
        check("stall_imm", 64'(out_imm), 64'hFFFF_FFFF);
        drain();

        // Immediate formats with simultaneous push/pop
        cycle(1, 32'h0020A423, 32'h200, 0, 0);
        check("sw_imm", 64'(out_imm), 64'd8);
        check("sw_rs1", 64'(out_rs1), 64'd1);
        check("sw_rs2", 64'(out_rs2), 64'd2);
        check("sw_rd", 64'(out_rd), 64'd0);
        cycle(1, 32'hFE000EE3, 32'h204, 1, 0);
        check("beq_imm", 64'(out_imm), 64'hFFFF_FFFC);
        cycle(1, 32'h123452B7, 32'h208, 1, 0);
        check("lui_imm", 64'(out_imm), 64'h1234_5000);
        check("lui_rd", 64'(out_rd), 64'd5);
        drain();

        // Full and backpressure
        cycle(1, 32'h002081B3, 32'h300, 0, 0);
        cycle(1, 32'h402081B3, 32'h304, 0, 0);
        check("full_ready", 64'(in_ready), 64'd0);
        cycle(1, 32'h0040A103, 32'h308, 0, 0);
        check("held_count", 64'(count), 64'd2);
        cycle(1, 32'h0040A103, 32'h308, 1, 0);
        check("restore_ready", 64'(in_ready), 64'd1);
        check("pop_head_pc", 64'(out_pc), 64'h304);
        cycle(1, 32'h0040A103, 32'h308, 0, 0);
        drain();

        // Pointer wrap over 10 accepted pushes with random backpressure
        n_acc = 0;
        for (int k = 0; k < 200 && n_acc < 10; k++) begin
            int j;
            j = $urandom_range(0, 13);
            cycle(1'($urandom_range(0, 1)), prog[j], XLEN'(32'h400 + 4 * k),
                  1'($urandom_range(0, 1)), 0);
        end
        check("wrap_pushes", 64'(n_acc), 64'd10);
        drain();

        // Steady simultaneous push/pop at count=1
        cycle(1, prog[0], 32'h500, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            cycle(1, prog[k], XLEN'(32'h500 + 4 * k), 1, 0);
            check("steady_count", 64'(count), 64'd1);
        end
        drain();

        // Illegal instructions
        cycle(1, 32'h0000007F, 32'h600, 0, 0);
        check("ill0", 64'(out_illegal), 64'd1);
        check("ill0_instr", 64'(out_instr), 64'h0000007F);
        cycle(1, 32'hFE000033, 32'h604, 1, 0);
        check("ill1", 64'(out_illegal), 64'd1);
        check("ill1_rd", 64'(out_rd), 64'd0);
        cycle(1, 32'h00001067, 32'h608, 1, 0);
        check("ill2", 64'(out_illegal), 64'd1);
        check("ill2_instr", 64'(out_instr), 64'h00001067);
        cycle(1, 32'h00002063, 32'h60C, 1, 0);
        cycle(1, 32'hFFF00090, 32'h610, 1, 0);
        drain();

        // Flush with a full queue and a same-cycle push
        cycle(1, prog[1], 32'h700, 0, 0);
        cycle(1, prog[2], 32'h704, 0, 0);
        cycle(1, prog[3], 32'h708, 1, 1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);
        cycle(1, prog[5], 32'h70C, 0, 0);
        check("post_flush_pc", 64'(out_pc), 64'h70C);
        drain();

        // Reset pulsed mid-stream
        cycle(1, prog[6], 32'h800, 0, 0);
        cycle(1, prog[7], 32'h804, 0, 0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check_zero_outputs("midrst");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        cycle(1, prog[8], 32'h900, 0, 0);
        check("after_rst_pc", 64'(out_pc), 64'h900);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
